// File: rtl/counter_chain_ctrl.sv
// Run controller for an external counter chain: clears the chain, enables it, and counts
// last-stage terminal counts up to a target. Optional watchdog under COUNTER_CHAIN_CTRL_WATCHDOG_EN.
module counter_chain_ctrl #(
    parameter int unsigned COUNT_WIDTH    = 16,
    parameter int unsigned WRAP_WIDTH     = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   abort,
    input  logic                   pause,
    input  logic [WRAP_WIDTH-1:0]  target_wraps,
    input  logic [COUNT_WIDTH-1:0] chain_count,
    input  logic                   chain_tc,
    output logic                   chain_enable,
    output logic                   chain_clear,
    output logic                   busy,
    output logic                   done,
    output logic [WRAP_WIDTH-1:0]  wrap_count,
    input  logic                   snap_req,
    output logic                   snap_valid,
    input  logic                   snap_ready,
    output logic [COUNT_WIDTH-1:0] snap_data,
    output logic                   fault
);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        RUN,
        PAUSE,
        DONE
`ifdef COUNTER_CHAIN_CTRL_WATCHDOG_EN
        , FAULT
`endif
    } state_t;

    localparam logic [WRAP_WIDTH-1:0] WRAP_ONE = WRAP_WIDTH'(1);

    state_t                state;
    logic [WRAP_WIDTH-1:0] target;
    logic [WRAP_WIDTH-1:0] wrap_next;
    logic                  tc_counted;

    assign wrap_next  = wrap_count + WRAP_ONE;
    assign tc_counted = chain_tc && chain_enable;

`ifdef COUNTER_CHAIN_CTRL_WATCHDOG_EN
    localparam int unsigned WD_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [WD_W-1:0] WD_ONE  = WD_W'(1);

    logic [WD_W-1:0] wd;
`else
    assign fault = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            target       <= '0;
            wrap_count   <= '0;
            chain_enable <= 1'b0;
            chain_clear  <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
`ifdef COUNTER_CHAIN_CTRL_WATCHDOG_EN
            wd           <= '0;
            fault        <= 1'b0;
`endif
        end else begin
            done        <= 1'b0;
            chain_clear <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && target_wraps != '0) begin
                        target      <= target_wraps;
                        wrap_count  <= '0;
                        chain_clear <= 1'b1;
                        busy        <= 1'b1;
                        state       <= CLEAR;
                    end
                end
                CLEAR: begin
                    if (abort) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        chain_enable <= 1'b1;
                        state        <= RUN;
`ifdef COUNTER_CHAIN_CTRL_WATCHDOG_EN
                        wd           <= '0;
`endif
                    end
                end
                RUN: begin
                    if (abort) begin
                        chain_enable <= 1'b0;
                        busy         <= 1'b0;
                        state        <= IDLE;
                    end else if (tc_counted) begin
                        // A terminal count is honoured even when pause rises in the same cycle.
                        wrap_count <= wrap_next;
`ifdef COUNTER_CHAIN_CTRL_WATCHDOG_EN
                        wd         <= '0;
`endif
                        if (wrap_next == target) begin
                            chain_enable <= 1'b0;
                            busy         <= 1'b0;
                            done         <= 1'b1;
                            state        <= DONE;
                        end else if (pause) begin
                            chain_enable <= 1'b0;
                            state        <= PAUSE;
                        end
                    end
`ifdef COUNTER_CHAIN_CTRL_WATCHDOG_EN
                    else if (wd == WD_LAST) begin
                        chain_enable <= 1'b0;
                        busy         <= 1'b0;
                        fault        <= 1'b1;
                        state        <= FAULT;
                    end else begin
                        wd <= wd + WD_ONE;
                        if (pause) begin
                            chain_enable <= 1'b0;
                            state        <= PAUSE;
                        end
                    end
`else
                    else if (pause) begin
                        chain_enable <= 1'b0;
                        state        <= PAUSE;
                    end
`endif
                end
                PAUSE: begin
                    if (abort) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (!pause) begin
                        chain_enable <= 1'b1;
                        state        <= RUN;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
`ifdef COUNTER_CHAIN_CTRL_WATCHDOG_EN
                FAULT: begin
                    if (abort) begin
                        fault <= 1'b0;
                        state <= IDLE;
                    end
                end
`endif
                default: begin
                    chain_enable <= 1'b0;
                    busy         <= 1'b0;
                    state        <= IDLE;
                end
            endcase
        end
    end

    // A request arriving with the handshake replaces the outgoing snapshot back-to-back.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            snap_valid <= 1'b0;
            snap_data  <= '0;
        end else if (snap_valid && snap_ready) begin
            if (snap_req) begin
                snap_data <= chain_count;
            end else begin
                snap_valid <= 1'b0;
            end
        end else if (!snap_valid && snap_req) begin
            snap_data  <= chain_count;
            snap_valid <= 1'b1;
        end
    end

endmodule

// File: tb/tb_counter_chain_ctrl.sv
// Directed bench for counter_chain_ctrl: vector table for the main run flow plus
// hand-written sequences for pause, abort, reset, snapshot and watchdog.
module tb_counter_chain_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, abort, pause, chain_tc;
    logic [15:0] target_wraps;
    logic [15:0] chain_count;
    logic        chain_enable, chain_clear, busy, done;
    logic [15:0] wrap_count;
    logic        snap_req, snap_valid, snap_ready;
    logic [15:0] snap_data;
    logic        fault;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    counter_chain_ctrl #(
        .COUNT_WIDTH   (16),
        .WRAP_WIDTH    (16),
        .TIMEOUT_CYCLES(50)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .abort       (abort),
        .pause       (pause),
        .target_wraps(target_wraps),
        .chain_count (chain_count),
        .chain_tc    (chain_tc),
        .chain_enable(chain_enable),
        .chain_clear (chain_clear),
        .busy        (busy),
        .done        (done),
        .wrap_count  (wrap_count),
        .snap_req    (snap_req),
        .snap_valid  (snap_valid),
        .snap_ready  (snap_ready),
        .snap_data   (snap_data),
        .fault       (fault)
    );

    typedef struct packed {
        logic        start;
        logic        abort;
        logic        pause;
        logic        tc;
        logic [15:0] target;
        logic        en;
        logic        clr;
        logic        busy;
        logic        done;
        logic [15:0] wc;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_ctrl(input string name, input logic en, input logic clr,
                              input logic bsy, input logic dn, input logic [15:0] wc);
        check({name, ".chain_enable"}, 32'(chain_enable), 32'(en));
        check({name, ".chain_clear"}, 32'(chain_clear), 32'(clr));
        check({name, ".busy"}, 32'(busy), 32'(bsy));
        check({name, ".done"}, 32'(done), 32'(dn));
        check({name, ".wrap_count"}, 32'(wrap_count), 32'(wc));
    endtask

    task automatic idle_inputs();
        start = 0; abort = 0; pause = 0; chain_tc = 0;
    endtask

    task automatic begin_run(input logic [15:0] tgt);
        target_wraps = tgt;
        start = 1;
        step();
        start = 0;
        step();
    endtask

    initial begin
        //           start abort pause tc target  en clr busy done wc
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'd2, 1'b0, 1'b1, 1'b1, 1'b0, 16'd0};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'd2, 1'b1, 1'b0, 1'b1, 1'b0, 16'd0};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'd2, 1'b1, 1'b0, 1'b1, 1'b0, 16'd0};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 16'd2, 1'b1, 1'b0, 1'b1, 1'b0, 16'd1};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'd2, 1'b1, 1'b0, 1'b1, 1'b0, 16'd1};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 16'd2, 1'b0, 1'b0, 1'b0, 1'b1, 16'd2};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 16'd2, 1'b0, 1'b0, 1'b0, 1'b0, 16'd2};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd2};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'd1, 1'b0, 1'b1, 1'b1, 1'b0, 16'd0};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 1'b1, 16'd1, 1'b1, 1'b0, 1'b1, 1'b0, 16'd0};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 1'b1, 16'd1, 1'b0, 1'b0, 1'b0, 1'b1, 16'd1};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'd1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1};

        idle_inputs();
        target_wraps = 0; chain_count = 0; snap_req = 0; snap_ready = 0;
        reset = 1;
        step();
        step();
        check_ctrl("reset", 0, 0, 0, 0, 0);
        check("reset.fault", 32'(fault), 0);
        check("reset.snap_valid", 32'(snap_valid), 0);
        reset = 0;
        step();

        for (int i = 0; i < 12; i++) begin
            start = vecs[i].start; abort = vecs[i].abort; pause = vecs[i].pause;
            chain_tc = vecs[i].tc; target_wraps = vecs[i].target;
            step();
            check_ctrl($sformatf("vec%0d", i), vecs[i].en, vecs[i].clr, vecs[i].busy,
                       vecs[i].done, vecs[i].wc);
        end
        idle_inputs();
        step();

        // Pause: tc coincident with pause is counted; tcs during PAUSE are ignored.
        begin_run(16'd3);
        chain_tc = 1;
        step();
        check_ctrl("pause.tc1", 1, 0, 1, 0, 16'd1);
        pause = 1;
        step();
        check_ctrl("pause.enter", 0, 0, 1, 0, 16'd2);
        for (int i = 0; i < 6; i++) begin
            chain_tc = i[0];
            step();
            check_ctrl($sformatf("pause.hold%0d", i), 0, 0, 1, 0, 16'd2);
        end
        pause = 0; chain_tc = 0;
        step();
        check_ctrl("pause.resume", 1, 0, 1, 0, 16'd2);
        chain_tc = 1;
        step();
        check_ctrl("pause.done", 0, 0, 0, 1, 16'd3);
        idle_inputs();
        step();

        // Abort mid-run keeps wrap_count and gives no done pulse.
        begin_run(16'd5);
        chain_tc = 1;
        step();
        step();
        chain_tc = 0; abort = 1;
        step();
        check_ctrl("abort", 0, 0, 0, 0, 16'd2);
        abort = 0;
        step();
        check_ctrl("abort.after", 0, 0, 0, 0, 16'd2);

        // Asynchronous reset between clock edges.
        begin_run(16'd5);
        snap_req = 1; chain_count = 16'h00aa;
        step();
        snap_req = 0;
        #2 reset = 1;
        #1;
        check_ctrl("async_reset", 0, 0, 0, 0, 16'd0);
        check("async_reset.snap_valid", 32'(snap_valid), 0);
        check("async_reset.snap_data", 32'(snap_data), 0);
        step();
        check("async_reset.done", 32'(done), 0);
        reset = 0;
        step();

        // Snapshot hold, dropped request, then back-to-back capture on handshake.
        chain_count = 16'h1234; snap_req = 1;
        step();
        snap_req = 0;
        check("snap.valid", 32'(snap_valid), 1);
        check("snap.data", 32'(snap_data), 32'h1234);
        for (int i = 0; i < 4; i++) step();
        chain_count = 16'h5678; snap_req = 1;
        step();
        snap_req = 0;
        check("snap.drop", 32'(snap_data), 32'h1234);
        check("snap.drop_valid", 32'(snap_valid), 1);
        snap_ready = 1;
        step();
        snap_ready = 0;
        check("snap.consumed", 32'(snap_valid), 0);
        chain_count = 16'h1111; snap_req = 1;
        step();
        check("snap.cap2", 32'(snap_data), 32'h1111);
        chain_count = 16'h2222; snap_ready = 1;
        step();
        snap_req = 0; snap_ready = 0;
        check("snap.b2b_data", 32'(snap_data), 32'h2222);
        check("snap.b2b_valid", 32'(snap_valid), 1);

        // Watchdog: RUN with no tc.
        begin_run(16'd4);
`ifdef COUNTER_CHAIN_CTRL_WATCHDOG_EN
        for (int i = 0; i < 49; i++) step();
        check("wd.before", 32'(fault), 0);
        check("wd.before_en", 32'(chain_enable), 1);
        step();
        check("wd.fault", 32'(fault), 1);
        check_ctrl("wd.fault", 0, 0, 0, 0, 16'd0);
        step();
        check("wd.sticky", 32'(fault), 1);
        abort = 1;
        step();
        abort = 0;
        check("wd.cleared", 32'(fault), 0);
`else
        for (int i = 0; i < 60; i++) step();
        check("wd.absent", 32'(fault), 0);
        check("wd.absent_en", 32'(chain_enable), 1);
        abort = 1;
        step();
        abort = 0;
        check("wd.absent_abort", 32'(busy), 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
